// File: rtl/mac_acc_rtl.sv
// Stream reduction stage: sums the low C_IN_W bits of every input beat up to tlast,
// then emits one summary beat. Optional macro MAC_ACC_SATURATE_EN clamps acc instead of wrapping.
module mac_acc_rtl #(
    parameter int unsigned C_S_AXIS_IN_TDATA_WIDTH  = 1024,
    parameter int unsigned C_M_AXIS_OUT_TDATA_WIDTH = 1024,
    parameter int unsigned C_IN_W                   = 16,
    parameter int unsigned C_ACC_W                  = 32
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    s_axis_in_tvalid,
    output logic                                    s_axis_in_tready,
    input  logic [C_S_AXIS_IN_TDATA_WIDTH-1:0]      s_axis_in_tdata,
    input  logic [C_S_AXIS_IN_TDATA_WIDTH/8-1:0]    s_axis_in_tkeep,
    input  logic                                    s_axis_in_tlast,
    output logic                                    m_axis_out_tvalid,
    input  logic                                    m_axis_out_tready,
    output logic [C_M_AXIS_OUT_TDATA_WIDTH-1:0]     m_axis_out_tdata,
    output logic [C_M_AXIS_OUT_TDATA_WIDTH/8-1:0]   m_axis_out_tkeep,
    output logic                                    m_axis_out_tlast,
    input  logic                                    ap_start,
    output logic                                    ap_idle,
    output logic                                    ap_done,
    output logic                                    ap_ready
);

    localparam int unsigned IN_W   = C_S_AXIS_IN_TDATA_WIDTH;
    localparam int unsigned OUT_W  = C_M_AXIS_OUT_TDATA_WIDTH;
    localparam int unsigned KEEP_W = OUT_W / 8;
    localparam int unsigned SUM_W  = C_ACC_W + 1;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 start_d;
    logic [C_ACC_W-1:0]   acc;
    logic [C_ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic                 done_nxt;
    logic                 in_ready;
    logic                 out_valid;
    logic                 idle;
    logic                 done;
    logic                 start_pulse_c;
    logic                 in_fire_c;
    logic                 out_fire_c;
    logic [SUM_W-1:0]     sum_c;
    logic                 unused_in_c;

    assign start_pulse_c = ap_start & ~start_d;
    assign in_fire_c     = in_ready & s_axis_in_tvalid;
    assign out_fire_c    = out_valid & m_axis_out_tready;
    assign unused_in_c   = ^{s_axis_in_tkeep, s_axis_in_tdata[IN_W-1:C_IN_W]};

    // State, datapath and registered handshake outputs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            start_d   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            idle      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            start_d   <= ap_start;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            in_ready  <= (next_state == S_ACC);
            out_valid <= (next_state == S_EMIT);
            idle      <= (next_state == S_IDLE);
            done      <= done_nxt;
        end
    end

    always_comb begin
        next_state = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        ovf_nxt    = ovf;
        done_nxt   = 1'b0;
        sum_c      = SUM_W'(acc) + SUM_W'(s_axis_in_tdata[C_IN_W-1:0]);
        unique case (state)
            S_IDLE: begin
                if (start_pulse_c) begin
                    next_state = S_ACC;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    ovf_nxt    = 1'b0;
                end
            end
            S_ACC: begin
                if (in_fire_c) begin
`ifdef MAC_ACC_SATURATE_EN
                    acc_nxt = sum_c[C_ACC_W] ? '1 : sum_c[C_ACC_W-1:0];
`else
                    acc_nxt = sum_c[C_ACC_W-1:0];
`endif
                    cnt_nxt = cnt + CNT_W'(1);
                    ovf_nxt = ovf | sum_c[C_ACC_W];
                    if (s_axis_in_tlast) begin
                        next_state = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_fire_c) begin
                    next_state = S_IDLE;
                    done_nxt   = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Summary payload is built from registers only, so it holds steady while stalled
    assign m_axis_out_tdata  = out_valid ? OUT_W'({ovf, cnt, 64'(acc)}) : '0;
    assign m_axis_out_tkeep  = {KEEP_W{out_valid}};
    assign m_axis_out_tlast  = out_valid;
    assign m_axis_out_tvalid = out_valid;
    assign s_axis_in_tready  = in_ready;
    assign ap_idle           = idle;
    assign ap_done           = done;
    assign ap_ready          = done;

endmodule
